// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for the EX stage; result is {remainder, quotient}.
// Define DIV_EARLY_EXIT_EN to finish early when |divisor| > |dividend|.
module ex_div #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [2*DATA_W-1:0] result_d;
  logic                ready_d;

  logic                a_neg, b_neg, early;
  logic [DATA_W-1:0]   abs_a, abs_b, quo_fix, rem_fix;
  logic [DATA_W:0]     shifted, diff;

  assign a_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign b_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign abs_a = a_neg ? -opdata1_i : opdata1_i;
  assign abs_b = b_neg ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_EXIT_EN
  assign early = (abs_b > abs_a);
`else
  assign early = 1'b0;
`endif

  // One restoring step: dvd_q holds the remaining dividend bits and collects quotient bits.
  assign shifted = {rem_q, dvd_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  assign quo_fix = qneg_q ? -dvd_q : dvd_q;
  assign rem_fix = rneg_q ? -rem_q : rem_q;

  assign stallreq_o = start_i & ~annul_i & ~ready_o;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_o;
    ready_d  = ready_o;
    unique case (state_q)
      StFree: begin
        if (start_i && !annul_i) begin
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          dvs_d  = abs_b;
          cnt_d  = '0;
          if (opdata2_i == '0) begin
            state_d = StByZero;
            dvd_d   = '0;
            rem_d   = '0;
          end else if (early) begin
            // Short path shares the by-zero state: q=0, remainder is the dividend.
            state_d = StByZero;
            dvd_d   = '0;
            rem_d   = abs_a;
          end else begin
            state_d = StOn;
            dvd_d   = abs_a;
            rem_d   = '0;
          end
        end
      end
      StByZero: begin
        state_d = StEnd;
      end
      StOn: begin
        if (annul_i) begin
          state_d = StFree;
        end else begin
          dvd_d = {dvd_q[DATA_W-2:0], ~diff[DATA_W]};
          rem_d = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DATA_W - 1)) begin
            state_d = StEnd;
          end
        end
      end
      StEnd: begin
        if (annul_i) begin
          state_d  = StFree;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (!ready_o) begin
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
        end else if (!start_i) begin
          state_d  = StFree;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = StFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFree;
      cnt_q    <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

endmodule
